// File: rtl/commit_tracer_if.sv
// Retire-trace bundle: decode/hazard-side inputs toward the tracer, commit record and status back.
// The CPU side (or a bench) is master; commit_tracer is slave.
interface commit_tracer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [XLEN-1:0]  id_pc_i;
    logic [XLEN-1:0]  id_inst_i;
    logic             flush_i;
    logic             stall_i;
    logic             commit_valid_o;
    logic [XLEN-1:0]  commit_pc_o;
    logic [XLEN-1:0]  commit_inst_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] retired_cnt_o;
    logic             done_o;
    logic             timeout_o;

    modport master (
        output start_i, id_pc_i, id_inst_i, flush_i, stall_i,
        input  commit_valid_o, commit_pc_o, commit_inst_o,
               cycle_cnt_o, retired_cnt_o, done_o, timeout_o
    );

    modport slave (
        input  start_i, id_pc_i, id_inst_i, flush_i, stall_i,
        output commit_valid_o, commit_pc_o, commit_inst_o,
               cycle_cnt_o, retired_cnt_o, done_o, timeout_o
    );
endinterface

// File: rtl/commit_tracer.sv
// Retire-trace monitor: shadows ID-exit PC/encoding through DEPTH slots, reports one record per retire.
// Commit visible DEPTH-1 edges after capture; no backpressure, outputs derive from registered state only.
module commit_tracer #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 3,
    parameter int              CNT_W      = 32,
    parameter logic [XLEN-1:0] END_INST   = '0,
    parameter int unsigned     PC_BIAS    = 0,
    parameter int              MAX_CYCLES = 4096
) (
    input  logic            clk_i,
    input  logic            rst_i,
    commit_tracer_if.slave  trc
);
    localparam logic [XLEN-1:0] BIAS = XLEN'(PC_BIAS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } slot_t;

    state_t           state;
    slot_t            slots [DEPTH];
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;
    logic             done_q;
    logic             timeout_q;

    logic             end_hit;
    logic             wd_hit;
    logic             commit_vld;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign end_hit    = (state == RUN) && slots[DEPTH-1].vld && (slots[DEPTH-1].inst == END_INST);
    assign commit_vld = (state == RUN) && slots[DEPTH-1].vld && (slots[DEPTH-1].inst != END_INST);
    // 64-bit compare keeps large MAX_CYCLES from aliasing onto a narrow counter.
    assign wd_hit     = (MAX_CYCLES != 0) && (state == RUN) &&
                        (64'(cycle_cnt) == 64'(MAX_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (trc.start_i) begin
                        state    <= RUN;
                        slots[0] <= '{vld: ~trc.flush_i, pc: trc.id_pc_i, inst: trc.id_inst_i};
                    end
                end
                RUN: begin
                    if (commit_vld) begin
                        retired_cnt <= sat_inc(retired_cnt);
                    end
                    // END outranks the watchdog; the transition edge itself freezes the pipe.
                    if (end_hit) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (wd_hit) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cycle_cnt <= sat_inc(cycle_cnt);
                        slots[0]  <= '{vld: ~trc.flush_i, pc: trc.id_pc_i, inst: trc.id_inst_i};
                        slots[1]  <= '{vld: slots[0].vld & ~trc.stall_i,
                                       pc: slots[0].pc, inst: slots[0].inst};
                        for (int k = 2; k < DEPTH; k++) begin
                            slots[k] <= slots[k-1];
                        end
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

    assign trc.commit_valid_o = commit_vld;
    assign trc.commit_pc_o    = slots[DEPTH-1].pc + BIAS;
    assign trc.commit_inst_o  = slots[DEPTH-1].inst;
    assign trc.cycle_cnt_o    = cycle_cnt;
    assign trc.retired_cnt_o  = retired_cnt;
    assign trc.done_o         = done_q;
    assign trc.timeout_o      = timeout_q;
endmodule

// File: tb/tb_commit_tracer.sv
// Bench for commit_tracer: instance A (bias 0x10008, watchdog 20), instance B (4-bit counters, no watchdog).
module tb_commit_tracer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_inst = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    commit_tracer_if #(.XLEN(32), .CNT_W(32)) a_if ();
    commit_tracer_if #(.XLEN(32), .CNT_W(4))  b_if ();

    assign a_if.start_i   = start;
    assign a_if.id_pc_i   = id_pc;
    assign a_if.id_inst_i = id_inst;
    assign a_if.flush_i   = flush;
    assign a_if.stall_i   = stall;
    assign b_if.start_i   = start;
    assign b_if.id_pc_i   = id_pc;
    assign b_if.id_inst_i = id_inst;
    assign b_if.flush_i   = flush;
    assign b_if.stall_i   = stall;

    commit_tracer #(.XLEN(32), .DEPTH(3), .CNT_W(32), .END_INST(32'h0),
                    .PC_BIAS(65544), .MAX_CYCLES(20)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .trc   (a_if.slave)
    );

    commit_tracer #(.XLEN(32), .DEPTH(3), .CNT_W(4), .END_INST(32'h0),
                    .PC_BIAS(0), .MAX_CYCLES(0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .trc   (b_if.slave)
    );

    typedef struct {
        bit          rst_before;
        bit          start;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          flush;
        bit          stall;
        bit          e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        int          e_ret;
        bit          e_done;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(bit r, bit s, logic [31:0] pc, logic [31:0] inst, bit fl, bit st,
                                bit ev, logic [31:0] ep, logic [31:0] ei, int er, bit ed);
        vec_t v;
        v.rst_before = r; v.start = s; v.pc = pc; v.inst = inst; v.flush = fl; v.stall = st;
        v.e_vld = ev; v.e_pc = ep; v.e_inst = ei; v.e_ret = er; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0; flush = 1'b0; stall = 1'b0; id_pc = '0; id_inst = '0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Straight-line program: END sits at pc 8; fillers after it never commit.
        tbl[0]  = mk(1, 1, 32'h000, 32'h00500093, 0, 0, 0, 32'h10008, 32'h0,        0, 0);
        tbl[1]  = mk(0, 0, 32'h004, 32'h00208133, 0, 0, 0, 32'h10008, 32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 32'h008, 32'h00000000, 0, 0, 1, 32'h10008, 32'h00500093, 0, 0);
        tbl[3]  = mk(0, 0, 32'h00C, 32'h00000013, 0, 0, 1, 32'h1000C, 32'h00208133, 1, 0);
        tbl[4]  = mk(0, 0, 32'h010, 32'h00000013, 0, 0, 0, 32'h10010, 32'h0,        2, 0);
        tbl[5]  = mk(0, 0, 32'h014, 32'h00000013, 0, 0, 0, 32'h10010, 32'h0,        2, 1);
        tbl[6]  = mk(0, 1, 32'h018, 32'h00000013, 1, 1, 0, 32'h10010, 32'h0,        2, 1);
        // Stall at edge 2 kills I1, flush at edge 3 kills I3; I6 is END.
        tbl[7]  = mk(1, 1, 32'h100, 32'h00000111, 0, 0, 0, 32'h10008, 32'h0,        0, 0);
        tbl[8]  = mk(0, 0, 32'h104, 32'h00000222, 0, 0, 0, 32'h10008, 32'h0,        0, 0);
        tbl[9]  = mk(0, 0, 32'h108, 32'h00000333, 0, 1, 1, 32'h10108, 32'h111,      0, 0);
        tbl[10] = mk(0, 0, 32'h10C, 32'h00000444, 1, 0, 0, 32'h1010C, 32'h222,      1, 0);
        tbl[11] = mk(0, 0, 32'h110, 32'h00000555, 0, 0, 1, 32'h10110, 32'h333,      1, 0);
        tbl[12] = mk(0, 0, 32'h114, 32'h00000666, 0, 0, 0, 32'h10114, 32'h444,      2, 0);
        tbl[13] = mk(0, 0, 32'h118, 32'h00000000, 0, 0, 1, 32'h10118, 32'h555,      2, 0);
        tbl[14] = mk(0, 0, 32'h11C, 32'h00000777, 0, 0, 1, 32'h1011C, 32'h666,      3, 0);
        tbl[15] = mk(0, 0, 32'h120, 32'h00000777, 0, 0, 0, 32'h10120, 32'h0,        4, 0);
        tbl[16] = mk(0, 0, 32'h124, 32'h00000777, 0, 0, 0, 32'h10120, 32'h0,        4, 1);

        #1;
        chk("rst_vld",  64'(a_if.commit_valid_o), 64'd0);
        chk("rst_pc",   64'(a_if.commit_pc_o),    64'h10008);
        chk("rst_inst", 64'(a_if.commit_inst_o),  64'd0);
        chk("rst_cyc",  64'(a_if.cycle_cnt_o),    64'd0);
        chk("rst_ret",  64'(a_if.retired_cnt_o),  64'd0);
        chk("rst_done", 64'(a_if.done_o),         64'd0);
        chk("rst_to",   64'(a_if.timeout_o),      64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst_before) do_reset();
            start = tbl[i].start; id_pc = tbl[i].pc; id_inst = tbl[i].inst;
            flush = tbl[i].flush; stall = tbl[i].stall;
            step();
            chk($sformatf("vec%0d_vld", i),  64'(a_if.commit_valid_o), 64'(tbl[i].e_vld));
            chk($sformatf("vec%0d_pc", i),   64'(a_if.commit_pc_o),    64'(tbl[i].e_pc));
            chk($sformatf("vec%0d_inst", i), 64'(a_if.commit_inst_o),  64'(tbl[i].e_inst));
            chk($sformatf("vec%0d_ret", i),  64'(a_if.retired_cnt_o),  64'(tbl[i].e_ret));
            chk($sformatf("vec%0d_done", i), 64'(a_if.done_o),         64'(tbl[i].e_done));
        end
        start = 1'b0; flush = 1'b0; stall = 1'b0;

        // Asynchronous reset mid-run, then five idle edges.
        do_reset();
        start = 1'b1; id_pc = 32'h40; id_inst = 32'h13;
        step();
        start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            id_pc = 32'h40 + 32'(4 * n);
            step();
        end
        chk("mid_cyc_pre", 64'(a_if.cycle_cnt_o), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_vld",  64'(a_if.commit_valid_o), 64'd0);
        chk("mid_pc",   64'(a_if.commit_pc_o),    64'h10008);
        chk("mid_inst", 64'(a_if.commit_inst_o),  64'd0);
        chk("mid_cyc",  64'(a_if.cycle_cnt_o),    64'd0);
        chk("mid_ret",  64'(a_if.retired_cnt_o),  64'd0);
        chk("mid_done", 64'(a_if.done_o),         64'd0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("idle%0d_cyc", n), 64'(a_if.cycle_cnt_o),    64'd0);
            chk($sformatf("idle%0d_vld", n), 64'(a_if.commit_valid_o), 64'd0);
        end

        // Watchdog: endless non-END stream, fires on the 20th RUN edge.
        do_reset();
        start = 1'b1; id_pc = 32'h0; id_inst = 32'h13;
        step();
        start = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            id_pc = 32'(4 * n);
            step();
        end
        chk("wd_pre_done", 64'(a_if.done_o),         64'd0);
        chk("wd_pre_cyc",  64'(a_if.cycle_cnt_o),    64'd19);
        chk("wd_pre_vld",  64'(a_if.commit_valid_o), 64'd1);
        step();
        chk("wd_done", 64'(a_if.done_o),         64'd1);
        chk("wd_to",   64'(a_if.timeout_o),      64'd1);
        chk("wd_cyc",  64'(a_if.cycle_cnt_o),    64'd19);
        chk("wd_vld",  64'(a_if.commit_valid_o), 64'd0);
        for (int n = 0; n < 3; n++) begin
            start = 1'b1;
            step();
            chk($sformatf("wd_hold%0d_cyc", n), 64'(a_if.cycle_cnt_o),    64'd19);
            chk($sformatf("wd_hold%0d_vld", n), 64'(a_if.commit_valid_o), 64'd0);
        end
        start = 1'b0;

        // END captured at RUN edge 17 reaches the decision on edge 20, same as the watchdog.
        do_reset();
        start = 1'b1; id_pc = 32'h0; id_inst = 32'h13;
        step();
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            id_pc   = 32'(4 * n);
            id_inst = (n == 17) ? 32'h0 : 32'h13;
            step();
            if (n == 19) begin
                chk("sim_pre_done", 64'(a_if.done_o),         64'd0);
                chk("sim_pre_vld",  64'(a_if.commit_valid_o), 64'd0);
            end
        end
        chk("sim_done", 64'(a_if.done_o),    64'd1);
        chk("sim_to",   64'(a_if.timeout_o), 64'd0);

        // Saturation on the 4-bit instance.
        do_reset();
        start = 1'b1; id_pc = 32'h0; id_inst = 32'h93;
        step();
        start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            id_pc   = 32'(4 * n);
            id_inst = 32'h13 + 32'(n << 7);
            step();
            if (n == 15) begin
                chk("sat_mid_cyc", 64'(b_if.cycle_cnt_o),   64'd15);
                chk("sat_mid_ret", 64'(b_if.retired_cnt_o), 64'd13);
            end
        end
        chk("sat_cyc",  64'(b_if.cycle_cnt_o),    64'd15);
        chk("sat_ret",  64'(b_if.retired_cnt_o),  64'd15);
        chk("sat_done", 64'(b_if.done_o),         64'd0);
        chk("sat_vld",  64'(b_if.commit_valid_o), 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
